// File: rtl/ttt_board_ctrl.sv
// rtl/ttt_board_ctrl.sv - tic-tac-toe board state writer with move handshake and win/draw detection
module ttt_board_ctrl #(
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_cell,
  output logic       move_ready,
  output logic       move_accept,
  output logic       move_reject,
  output logic [1:0] t11,
  output logic [1:0] t12,
  output logic [1:0] t13,
  output logic [1:0] t21,
  output logic [1:0] t22,
  output logic [1:0] t23,
  output logic [1:0] t31,
  output logic [1:0] t32,
  output logic [1:0] t33,
  output logic [1:0] turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] move_count
);

  typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

  state_t      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [1:0]  turn_q, turn_d;
  logic        game_over_q, game_over_d;
  logic [1:0]  winner_q, winner_d;
  logic [3:0]  move_count_q, move_count_d;
  logic        move_accept_q, move_accept_d;
  logic        move_reject_q, move_reject_d;

  logic [1:0]  cells [9];
  logic [1:0]  target;
  logic [1:0]  line_win;

  function automatic logic [1:0] line3(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] c);
    return ((a != 2'b00) && (a == b) && (b == c)) ? a : 2'b00;
  endfunction

  always_comb begin
    for (int i = 0; i < 9; i++) cells[i] = board_q[2*i +: 2];
  end

  // Out-of-range indices read as "occupied" so they fall into the reject path.
  always_comb begin
    target = 2'b11;
    for (int i = 0; i < 9; i++) begin
      if (move_cell == 4'(i)) target = cells[i];
    end
  end

  always_comb begin
    line_win = 2'b00;
    if      (line3(cells[0], cells[1], cells[2]) != 2'b00) line_win = cells[0];
    else if (line3(cells[3], cells[4], cells[5]) != 2'b00) line_win = cells[3];
    else if (line3(cells[6], cells[7], cells[8]) != 2'b00) line_win = cells[6];
    else if (line3(cells[0], cells[3], cells[6]) != 2'b00) line_win = cells[0];
    else if (line3(cells[1], cells[4], cells[7]) != 2'b00) line_win = cells[1];
    else if (line3(cells[2], cells[5], cells[8]) != 2'b00) line_win = cells[2];
    else if (line3(cells[0], cells[4], cells[8]) != 2'b00) line_win = cells[0];
    else if (line3(cells[2], cells[4], cells[6]) != 2'b00) line_win = cells[2];
  end

  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    turn_d        = turn_q;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    move_count_d  = move_count_q;
    move_accept_d = 1'b0;
    move_reject_d = 1'b0;

    if (new_game) begin
      state_d      = PLAY;
      board_d      = '0;
      turn_d       = FIRST_PLAYER;
      game_over_d  = 1'b0;
      winner_d     = 2'b00;
      move_count_d = 4'd0;
    end else begin
      case (state_q)
        PLAY: begin
          if (move_valid) begin
            if ((move_cell <= 4'd8) && (target == 2'b00)) begin
              for (int i = 0; i < 9; i++) begin
                if (move_cell == 4'(i)) board_d[2*i +: 2] = turn_q;
              end
              move_count_d  = move_count_q + 4'd1;
              move_accept_d = 1'b1;
              state_d       = CHECK;
            end else begin
              move_reject_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (line_win != 2'b00) begin
            winner_d    = line_win;
            game_over_d = 1'b1;
            state_d     = DONE;
          end else if (move_count_q == 4'd9) begin
            winner_d    = 2'b11;
            game_over_d = 1'b1;
            state_d     = DONE;
          end else begin
            turn_d  = (turn_q == 2'b01) ? 2'b10 : 2'b01;
            state_d = PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PLAY;
      board_q       <= '0;
      turn_q        <= FIRST_PLAYER;
      game_over_q   <= 1'b0;
      winner_q      <= 2'b00;
      move_count_q  <= 4'd0;
      move_accept_q <= 1'b0;
      move_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      board_q       <= board_d;
      turn_q        <= turn_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      move_count_q  <= move_count_d;
      move_accept_q <= move_accept_d;
      move_reject_q <= move_reject_d;
    end
  end

  assign move_ready  = (state_q == PLAY);
  assign move_accept = move_accept_q;
  assign move_reject = move_reject_q;
  assign turn        = turn_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;
  assign move_count  = move_count_q;
  assign t11 = cells[0];
  assign t12 = cells[1];
  assign t13 = cells[2];
  assign t21 = cells[3];
  assign t22 = cells[4];
  assign t23 = cells[5];
  assign t31 = cells[6];
  assign t32 = cells[7];
  assign t33 = cells[8];

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// tb/tb_ttt_board_ctrl.sv - randomized and directed bench for ttt_board_ctrl against a game-rules model
module tb_ttt_board_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_game = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_cell = 4'd0;
  logic       move_ready, move_accept, move_reject, game_over;
  logic [1:0] t11, t12, t13, t21, t22, t23, t31, t32, t33, turn, winner;
  logic [3:0] move_count;

  int tests = 0;
  int fails = 0;

  // game-rules model
  int m_board [9];
  int m_turn, m_count, m_winner;
  bit m_over, m_acc, m_rej, m_eval_pending;

  ttt_board_ctrl #(.FIRST_PLAYER(2'b01)) dut (
    .clk(clk), .rst(rst), .new_game(new_game),
    .move_valid(move_valid), .move_cell(move_cell),
    .move_ready(move_ready), .move_accept(move_accept), .move_reject(move_reject),
    .t11(t11), .t12(t12), .t13(t13), .t21(t21), .t22(t22), .t23(t23),
    .t31(t31), .t32(t32), .t33(t33),
    .turn(turn), .game_over(game_over), .winner(winner), .move_count(move_count)
  );

  always #5 clk = ~clk;

  function automatic int rules_winner();
    int a, b, c;
    for (int k = 0; k < 8; k++) begin
      if (k < 3)       begin a = 3*k; b = 3*k + 1; c = 3*k + 2; end
      else if (k < 6)  begin a = k - 3; b = k; c = k + 3; end
      else if (k == 6) begin a = 0; b = 4; c = 8; end
      else             begin a = 2; b = 4; c = 6; end
      if (m_board[a] != 0 && m_board[a] == m_board[b] && m_board[b] == m_board[c])
        return m_board[a];
    end
    return 0;
  endfunction

  task automatic model_clear();
    foreach (m_board[i]) m_board[i] = 0;
    m_turn = 1; m_count = 0; m_winner = 0;
    m_over = 0; m_acc = 0; m_rej = 0; m_eval_pending = 0;
  endtask

  task automatic model_step();
    int w;
    if (rst || new_game) begin
      model_clear();
    end else begin
      m_acc = 0;
      m_rej = 0;
      if (m_eval_pending) begin
        m_eval_pending = 0;
        w = rules_winner();
        if (w != 0) begin m_winner = w; m_over = 1; end
        else if (m_count == 9) begin m_winner = 3; m_over = 1; end
        else m_turn = 3 - m_turn;
      end else if (!m_over && move_valid) begin
        if (move_cell <= 8 && m_board[move_cell] == 0) begin
          m_board[move_cell] = m_turn;
          m_count++;
          m_acc = 1;
          m_eval_pending = 1;
        end else begin
          m_rej = 1;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    int dc [9];
    dc = '{int'(t11), int'(t12), int'(t13), int'(t21), int'(t22), int'(t23),
           int'(t31), int'(t32), int'(t33)};
    for (int i = 0; i < 9; i++) check($sformatf("cell%0d", i), dc[i], m_board[i]);
    check("turn", turn, m_turn);
    check("move_count", move_count, m_count);
    check("winner", winner, m_winner);
    check("game_over", game_over, m_over);
    check("move_accept", move_accept, m_acc);
    check("move_reject", move_reject, m_rej);
    check("move_ready", move_ready, !m_over && !m_eval_pending);
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cyc(input logic r, input logic ng, input logic v, input logic [3:0] c);
    rst = r; new_game = ng; move_valid = v; move_cell = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic play_move(input logic [3:0] c);
    bit done = 0;
    for (int k = 0; k < 8 && !done; k++) begin
      cyc(0, 0, 1, c);
      if (move_accept || move_reject) done = 1;
    end
    if (!done) begin
      fails++; tests++;
      $display("FAIL play_move_timeout cell %0d: got no accept/reject expected one within 8 cycles", c);
    end
  endtask

  initial begin
    int last_acc, gaps_bad, acc_seen, idx;
    int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    model_clear();
    @(negedge clk);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("lit_reset_turn", turn, 1);
    check("lit_reset_ready", move_ready, 1);
    check("lit_reset_t22", t22, 0);
    check("lit_reset_count", move_count, 0);

    // row-one win for player 1
    play_move(0); play_move(3); play_move(1); play_move(4); play_move(2);
    cyc(0, 0, 0, 0);
    check("lit_win_winner", winner, 1);
    check("lit_win_over", game_over, 1);
    check("lit_win_ready", move_ready, 0);
    check("lit_win_t13", t13, 1);
    check("lit_win_t21", t21, 2);
    cyc(0, 0, 1, 8);
    cyc(0, 0, 1, 8);
    check("lit_done_t33", t33, 0);
    check("lit_done_count", move_count, 5);

    // clear from DONE with a simultaneous move
    cyc(0, 1, 1, 4);
    check("lit_ng_done_t11", t11, 0);
    check("lit_ng_done_acc", move_accept, 0);
    check("lit_ng_done_turn", turn, 1);

    // occupied and out-of-range rejects
    play_move(4);
    play_move(4);
    check("lit_rej_pulse", move_reject, 1);
    check("lit_rej_t22", t22, 1);
    check("lit_rej_turn", turn, 2);
    play_move(12);
    check("lit_rej12_pulse", move_reject, 1);
    check("lit_rej12_count", move_count, 1);

    // clear mid-game with a simultaneous move
    cyc(0, 1, 1, 0);
    check("lit_ng_mid_t22", t22, 0);
    check("lit_ng_mid_rej", move_reject, 0);

    // draw
    foreach (draw_seq[i]) play_move(4'(draw_seq[i]));
    cyc(0, 0, 0, 0);
    check("lit_draw_count", move_count, 9);
    check("lit_draw_winner", winner, 3);
    check("lit_draw_over", game_over, 1);
    cyc(0, 1, 1, 2);
    check("lit_ng_draw_t31", t31, 0);

    // back-to-back: valid held, cell advances on each accept
    idx = 0; last_acc = -1; gaps_bad = 0; acc_seen = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(0, 0, 1, 4'(idx));
      if (move_accept) begin
        if (last_acc >= 0 && k - last_acc != 2) gaps_bad++;
        last_acc = k; acc_seen++; idx++;
      end
    end
    check("lit_b2b_gaps", gaps_bad, 0);
    check("lit_b2b_accepts", acc_seen, 6);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 255) == 0), ($urandom_range(0, 47) == 0),
          ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
